// File: rtl/alu_operand_seq.sv
// Operand issue stage for the 4-bit ALU: sweeps every (a,b) pair or issues one
// programmed pair, handing each pair downstream over a valid/ready handshake.
module alu_operand_seq #(
  parameter int WIDTH  = 4,
  parameter int STEP_B = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               single,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               abort,
  input  logic               ready,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   pair_cnt
);

  localparam int CW = 2*WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic             single_q, single_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   b_sum;
  logic             xfer, last;

  // The carry out of b+STEP_B is what advances a and detects the final pair.
  assign b_sum = {1'b0, b_q} + (WIDTH+1)'(STEP_B);
  assign xfer  = valid_q & ready;
  assign last  = xfer & (single_q | (b_sum[WIDTH] & (a_q == {WIDTH{1'b1}})));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    single_d = single_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          single_d = single;
          cnt_d    = '0;
          a_d      = single ? op_a : '0;
          b_d      = single ? op_b : '0;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          if (!single_q) begin
            b_d = b_sum[WIDTH-1:0];
            if (b_sum[WIDTH]) a_d = a_q + WIDTH'(1);
          end
        end
        // Abort takes priority over completion so an aborted run never pulses done.
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (last) begin
          state_d = DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      single_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      single_q <= single_d;
      cnt_q    <= cnt_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pair_cnt = cnt_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Self-checking bench for alu_operand_seq: a STEP_B=1 instance and a STEP_B=3
// instance share stimulus; expectations come from sweep arithmetic in the bench.
module tb_alu_operand_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, single, abort, ready;
  logic [3:0] op_a, op_b;
  logic [3:0] a1, b1, a3, b3;
  logic       valid1, busy1, done1, valid3, busy3, done3;
  logic [8:0] cnt1, cnt3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_operand_seq #(.WIDTH(4), .STEP_B(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .single(single),
    .op_a(op_a), .op_b(op_b), .abort(abort), .ready(ready),
    .a(a1), .b(b1), .valid(valid1), .busy(busy1), .done(done1), .pair_cnt(cnt1)
  );

  alu_operand_seq #(.WIDTH(4), .STEP_B(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .single(single),
    .op_a(op_a), .op_b(op_b), .abort(abort), .ready(ready),
    .a(a3), .b(b3), .valid(valid3), .busy(busy3), .done(done3), .pair_cnt(cnt3)
  );

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; single = 0; abort = 0; ready = 1; op_a = 0; op_b = 0;
    cyc(); cyc();
    checks++;
    if ({a1, b1, valid1, busy1, done1, cnt1} !== 20'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got a=%0d b=%0d v=%b busy=%b done=%b cnt=%0d, want all zero",
               a1, b1, valid1, busy1, done1, cnt1);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_sweep();
    ready = 1; single = 0; start = 1;
    cyc();
    start = 0;
    for (int n = 0; n < 256; n++) begin
      checks++;
      if (valid1 !== 1'b1 || a1 !== 4'(n / 16) || b1 !== 4'(n % 16) || cnt1 !== 9'(n) || done1 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sweep_pair%0d: got v=%b a=%0d b=%0d cnt=%0d done=%b, want v=1 a=%0d b=%0d cnt=%0d done=0",
                 n, valid1, a1, b1, cnt1, done1, n / 16, n % 16, n);
      end
      cyc();
    end
    checks++;
    if (done1 !== 1'b1 || valid1 !== 1'b0 || busy1 !== 1'b0 || cnt1 !== 9'd256) begin
      errors++;
      $display("[TB] FAIL sweep_done: got done=%b v=%b busy=%b cnt=%0d, want done=1 v=0 busy=0 cnt=256",
               done1, valid1, busy1, cnt1);
    end
    cyc();
    checks++;
    if (done1 !== 1'b0 || cnt1 !== 9'd256) begin
      errors++;
      $display("[TB] FAIL sweep_after_done: got done=%b cnt=%0d, want done=0 cnt=256", done1, cnt1);
    end
  endtask

  task automatic test_backpressure();
    ready = 1; single = 0; start = 1;
    cyc();
    start = 0;
    repeat (5) cyc();
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (valid1 !== 1'b1 || a1 !== 4'd0 || b1 !== 4'd5 || cnt1 !== 9'd5) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got v=%b a=%0d b=%0d cnt=%0d, want v=1 a=0 b=5 cnt=5",
                 i, valid1, a1, b1, cnt1);
      end
    end
    ready = 1;
    cyc();
    checks++;
    if (a1 !== 4'd0 || b1 !== 4'd6 || cnt1 !== 9'd6) begin
      errors++;
      $display("[TB] FAIL stall_release: got a=%0d b=%0d cnt=%0d, want a=0 b=6 cnt=6", a1, b1, cnt1);
    end
    // A start pulse in RUN must not restart the sweep.
    start = 1;
    cyc();
    start = 0;
    checks++;
    if (a1 !== 4'd0 || b1 !== 4'd7 || cnt1 !== 9'd7 || busy1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_in_run: got a=%0d b=%0d cnt=%0d busy=%b, want a=0 b=7 cnt=7 busy=1",
               a1, b1, cnt1, busy1);
    end
    abort = 1;
    cyc();
    abort = 0;
    cyc();
  endtask

  task automatic test_single();
    logic [3:0] ra, rb;
    for (int i = 0; i < 4; i++) begin
      ra = (i == 0) ? 4'd6 : 4'($urandom_range(0, 15));
      rb = (i == 0) ? 4'd4 : 4'($urandom_range(0, 15));
      single = 1; op_a = ra; op_b = rb; start = 1;
      abort = (i == 1);
      ready = 0;
      cyc();
      start = 0; abort = 0; single = 0; op_a = ~ra; op_b = ~rb;
      checks++;
      if (valid1 !== 1'b1 || busy1 !== 1'b1 || a1 !== ra || b1 !== rb || cnt1 !== 9'd0) begin
        errors++;
        $display("[TB] FAIL single_load%0d: got v=%b busy=%b a=%0d b=%0d cnt=%0d, want v=1 busy=1 a=%0d b=%0d cnt=0",
                 i, valid1, busy1, a1, b1, cnt1, ra, rb);
      end
      ready = 1;
      cyc();
      checks++;
      if (done1 !== 1'b1 || valid1 !== 1'b0 || busy1 !== 1'b0 || cnt1 !== 9'd1) begin
        errors++;
        $display("[TB] FAIL single_done%0d: got done=%b v=%b busy=%b cnt=%0d, want done=1 v=0 busy=0 cnt=1",
                 i, done1, valid1, busy1, cnt1);
      end
      cyc();
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0 || cnt1 !== 9'd1) begin
        errors++;
        $display("[TB] FAIL single_idle%0d: got done=%b busy=%b cnt=%0d, want done=0 busy=0 cnt=1",
                 i, done1, busy1, cnt1);
      end
    end
  endtask

  task automatic test_abort();
    ready = 1; single = 0; start = 1;
    cyc();
    start = 0;
    repeat (20) cyc();
    abort = 1;
    cyc();
    abort = 0;
    checks++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || cnt1 !== 9'd21) begin
      errors++;
      $display("[TB] FAIL abort_drop: got v=%b busy=%b done=%b cnt=%0d, want v=0 busy=0 done=0 cnt=21",
               valid1, busy1, done1, cnt1);
    end
    abort = 1;
    cyc();
    abort = 0;
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || cnt1 !== 9'd21) begin
      errors++;
      $display("[TB] FAIL abort_idle: got done=%b busy=%b cnt=%0d, want done=0 busy=0 cnt=21",
               done1, busy1, cnt1);
    end
  endtask

  task automatic test_reset_mid();
    ready = 1; single = 0; start = 1;
    cyc();
    start = 0;
    repeat (57) cyc();
    checks++;
    if (a1 !== 4'd3 || b1 !== 4'd9) begin
      errors++;
      $display("[TB] FAIL reset_mid_pair: got a=%0d b=%0d, want a=3 b=9", a1, b1);
    end
    rst_n = 0;
    cyc();
    rst_n = 1;
    checks++;
    if ({a1, b1, valid1, busy1, done1, cnt1} !== 20'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_clear: got a=%0d b=%0d v=%b busy=%b done=%b cnt=%0d, want all zero",
               a1, b1, valid1, busy1, done1, cnt1);
    end
    start = 1;
    cyc();
    start = 0;
    checks++;
    if (valid1 !== 1'b1 || a1 !== 4'd0 || b1 !== 4'd0 || cnt1 !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_restart: got v=%b a=%0d b=%0d cnt=%0d, want v=1 a=0 b=0 cnt=0",
               valid1, a1, b1, cnt1);
    end
    abort = 1;
    cyc();
    abort = 0;
    cyc();
  endtask

  // STEP_B=3 sweep under random backpressure, tracked by running b total.
  task automatic test_step3_random();
    int  ea, eb, ecnt, sum;
    bit  finished;
    ea = 0; eb = 0; ecnt = 0; finished = 0;
    single = 0; ready = 1; start = 1;
    cyc();
    start = 0;
    for (int t = 0; t < 2000 && !finished; t++) begin
      checks++;
      if (valid3 !== 1'b1 || a3 !== 4'(ea) || b3 !== 4'(eb) || cnt3 !== 9'(ecnt) || done3 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL step3_pair%0d: got v=%b a=%0d b=%0d cnt=%0d done=%b, want v=1 a=%0d b=%0d cnt=%0d done=0",
                 t, valid3, a3, b3, cnt3, done3, ea, eb, ecnt);
      end
      ready = ($urandom % 4) != 0;
      if (ready) begin
        ecnt++;
        sum = eb + 3;
        if (sum >= 16) begin
          if (ea == 15) finished = 1;
          ea = (ea + 1) % 16;
        end
        eb = sum % 16;
      end
      cyc();
    end
    checks++;
    if (!finished || done3 !== 1'b1 || valid3 !== 1'b0 || busy3 !== 1'b0 || cnt3 !== 9'(ecnt)) begin
      errors++;
      $display("[TB] FAIL step3_done: finished=%b got done=%b v=%b busy=%b cnt=%0d, want done=1 v=0 busy=0 cnt=%0d",
               finished, done3, valid3, busy3, cnt3, ecnt);
    end
    abort = 1;
    cyc();
    abort = 0;
    ready = 1;
    repeat (2) cyc();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_backpressure();
    test_single();
    test_abort();
    test_reset_mid();
    test_step3_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
